// File: rtl/caliptra_apb_req_pkg.sv
// Shared types and default widths for the Caliptra APB requester.
package caliptra_apb_req_pkg;

  localparam int unsigned APB_ADDR_W         = 32;
  localparam int unsigned APB_DATA_W         = 32;
  localparam int unsigned APB_STRB_W         = APB_DATA_W / 8;
  localparam int unsigned APB_TIMEOUT_CYCLES = 1024;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  typedef struct packed {
    logic [APB_ADDR_W-1:0] addr;
    logic                  write;
    logic [APB_DATA_W-1:0] wdata;
    logic [APB_STRB_W-1:0] strb;
    logic [2:0]            prot;
  } apb_cmd_t;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb_rsp_t;

  // PSEL is asserted for the whole SETUP+ACCESS window of a transfer.
  function automatic logic apb_sel_state(input apb_state_e s);
    return (s == ST_SETUP) || (s == ST_ACCESS);
  endfunction

endpackage

// File: rtl/caliptra_apb_requester.sv
// APB4 requester: one transfer per valid/ready command, 4-cycle minimum period, response held until rsp_ready.
// Optional ACCESS-phase abort counter is built when CALIPTRA_APB_TIMEOUT_EN is defined.
module caliptra_apb_requester
  import caliptra_apb_req_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = APB_ADDR_W,
  parameter int unsigned DATA_WIDTH     = APB_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
  input  logic                    core_clk,
  input  logic                    cptra_rst_b,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic                    cmd_write,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  input  logic [2:0]              cmd_prot,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   m_apb_paddr,
  output logic                    m_apb_psel,
  output logic                    m_apb_penable,
  output logic                    m_apb_pwrite,
  output logic [DATA_WIDTH-1:0]   m_apb_pwdata,
  output logic [DATA_WIDTH/8-1:0] m_apb_pstrb,
  output logic [2:0]              m_apb_pprot,
  input  logic [DATA_WIDTH-1:0]   m_apb_prdata,
  input  logic                    m_apb_pready,
  input  logic                    m_apb_pslverr
);

  apb_state_e state_q, state_d;

  logic                    cmd_ready_q;
  logic                    psel_q, penable_q, pwrite_q;
  logic [ADDR_WIDTH-1:0]   paddr_q;
  logic [DATA_WIDTH-1:0]   pwdata_q;
  logic [DATA_WIDTH/8-1:0] pstrb_q;
  logic [2:0]              pprot_q;
  logic                    rsp_valid_q, rsp_err_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;

  logic cmd_fire, rsp_fire, access_done, timeout_hit;

  assign cmd_fire    = cmd_valid & cmd_ready_q;
  assign rsp_fire    = rsp_valid_q & rsp_ready;
  assign access_done = (state_q == ST_ACCESS) & (m_apb_pready | timeout_hit);

`ifdef CALIPTRA_APB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_timeout_q;

  // pready on the terminal-count cycle takes priority over the abort.
  assign timeout_hit = (state_q == ST_ACCESS) & ~m_apb_pready &
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_SETUP) begin
      cnt_d = '0;
    end else if ((state_q == ST_ACCESS) && !m_apb_pready) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge core_clk or negedge cptra_rst_b) begin
    if (!cptra_rst_b) begin
      cnt_q         <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (access_done) begin
        rsp_timeout_q <= timeout_hit;
      end
    end
  end

  assign rsp_timeout = rsp_timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (cmd_fire)    state_d = ST_SETUP;
      ST_SETUP:                   state_d = ST_ACCESS;
      ST_ACCESS: if (access_done) state_d = ST_RESP;
      ST_RESP:   if (rsp_fire)    state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so each one is a plain flop.
  always_ff @(posedge core_clk or negedge cptra_rst_b) begin
    if (!cptra_rst_b) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      pprot_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= (state_d == ST_IDLE);
      psel_q      <= apb_sel_state(state_d);
      penable_q   <= (state_d == ST_ACCESS);
      rsp_valid_q <= (state_d == ST_RESP);
      if (cmd_fire) begin
        paddr_q  <= cmd_addr;
        pwrite_q <= cmd_write;
        pwdata_q <= cmd_wdata;
        pstrb_q  <= cmd_write ? cmd_strb : '0;
        pprot_q  <= cmd_prot;
      end
      if (access_done) begin
        rsp_rdata_q <= (!pwrite_q && m_apb_pready) ? m_apb_prdata : '0;
        rsp_err_q   <= m_apb_pready ? m_apb_pslverr : 1'b1;
      end
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign m_apb_paddr   = paddr_q;
  assign m_apb_psel    = psel_q;
  assign m_apb_penable = penable_q;
  assign m_apb_pwrite  = pwrite_q;
  assign m_apb_pwdata  = pwdata_q;
  assign m_apb_pstrb   = pstrb_q;
  assign m_apb_pprot   = pprot_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_err       = rsp_err_q;

endmodule

// File: tb/tb_caliptra_apb_requester.sv
// Bench for caliptra_apb_requester: vector table plus reset, timeout and throughput sequences.
module tb_caliptra_apb_requester;
  import caliptra_apb_req_pkg::*;

  logic        core_clk, cptra_rst_b;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [31:0] m_apb_paddr, m_apb_pwdata, m_apb_prdata;
  logic        m_apb_psel, m_apb_penable, m_apb_pwrite, m_apb_pready, m_apb_pslverr;
  logic [3:0]  m_apb_pstrb;
  logic [2:0]  m_apb_pprot;

  caliptra_apb_requester #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .core_clk(core_clk), .cptra_rst_b(cptra_rst_b),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .m_apb_paddr(m_apb_paddr), .m_apb_psel(m_apb_psel), .m_apb_penable(m_apb_penable),
    .m_apb_pwrite(m_apb_pwrite), .m_apb_pwdata(m_apb_pwdata), .m_apb_pstrb(m_apb_pstrb),
    .m_apb_pprot(m_apb_pprot), .m_apb_prdata(m_apb_prdata), .m_apb_pready(m_apb_pready),
    .m_apb_pslverr(m_apb_pslverr)
  );

  initial core_clk = 1'b0;
  always #5 core_clk = ~core_clk;

  int n_checks = 0;
  int n_errors = 0;
  apb_rsp_t sb_q[$];

  typedef struct {
    apb_cmd_t    cmd;
    int          waits;
    logic [31:0] prdata;
    logic        slverr;
    int          hold;
    apb_rsp_t    exp;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge core_clk);
    #1;
  endtask

  // Response scoreboard and SETUP-before-ACCESS protocol monitor.
  logic prev_psel = 1'b0, prev_penable = 1'b0;
  always @(negedge core_clk) begin
    if (rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_rsp", 1'b1, 1'b0);
      end else begin
        apb_rsp_t e;
        e = sb_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", rsp_err, e.err);
        chk("rsp_timeout", rsp_timeout, e.timeout);
      end
    end
    if (m_apb_penable && !prev_penable) begin
      chk("setup_before_access", {prev_psel, prev_penable, m_apb_psel}, 3'b101);
    end
    prev_psel    = m_apb_psel;
    prev_penable = m_apb_penable;
  end

  task automatic drive_cmd(input apb_cmd_t c);
    cmd_addr  = c.addr;
    cmd_write = c.write;
    cmd_wdata = c.wdata;
    cmd_strb  = c.strb;
    cmd_prot  = c.prot;
  endtask

  task automatic wait_cmd_ready();
    int n = 0;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    chk("cmd_ready_wait", cmd_ready, 1'b1);
  endtask

  task automatic do_xfer(input vec_t v);
    logic [71:0] apb_exp;
    apb_exp = {v.cmd.addr, v.cmd.write, v.cmd.wdata, v.cmd.write ? v.cmd.strb : 4'h0, v.cmd.prot};
    wait_cmd_ready();
    drive_cmd(v.cmd);
    m_apb_pready = 1'b0;
    rsp_ready    = (v.hold == 0);
    cmd_valid    = 1'b1;
    sb_q.push_back(v.exp);
    tick();                                   // T+1
    cmd_valid = 1'b0;
    chk("setup_sel_en", {m_apb_psel, m_apb_penable, cmd_ready}, 3'b100);
    chk("setup_apb", {m_apb_paddr, m_apb_pwrite, m_apb_pwdata, m_apb_pstrb, m_apb_pprot}, apb_exp);
    tick();                                   // T+2
    for (int w = 0; w <= v.waits; w++) begin
      chk("access_sel_en", {m_apb_psel, m_apb_penable}, 2'b11);
      chk("access_apb", {m_apb_paddr, m_apb_pwrite, m_apb_pwdata, m_apb_pstrb, m_apb_pprot}, apb_exp);
      if (w == v.waits) begin
        m_apb_pready  = 1'b1;
        m_apb_prdata  = v.prdata;
        m_apb_pslverr = v.slverr;
      end
      tick();
    end
    m_apb_pready  = 1'b0;
    m_apb_pslverr = 1'b0;
    chk("resp_state", {m_apb_psel, m_apb_penable, rsp_valid, cmd_ready}, 4'b0010);
    chk("resp_data", {rsp_rdata, rsp_err, rsp_timeout}, v.exp);
    for (int h = 0; h < v.hold; h++) begin
      cmd_valid = 1'b1;
      tick();
      chk("hold_state", {rsp_valid, cmd_ready, m_apb_psel}, 3'b100);
      chk("hold_data", {rsp_rdata, rsp_err, rsp_timeout}, v.exp);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();                                   // T+4 when not held
    chk("back_to_idle", {rsp_valid, cmd_ready}, 2'b01);
  endtask

  vec_t vecs[5];
  int   setup_cyc[$];

  initial begin
    vecs[0] = '{cmd: '{32'h0000_0030, 1'b1, 32'hA5A5_5A5A, 4'hF, 3'b000}, waits: 0,
                prdata: 32'hFFFF_FFFF, slverr: 1'b0, hold: 0, exp: '{32'h0, 1'b0, 1'b0}};
    vecs[1] = '{cmd: '{32'h0000_0040, 1'b0, 32'h1111_2222, 4'hF, 3'b010}, waits: 3,
                prdata: 32'h1234_5678, slverr: 1'b0, hold: 0, exp: '{32'h1234_5678, 1'b0, 1'b0}};
    vecs[2] = '{cmd: '{32'h0000_0044, 1'b0, 32'h0, 4'h0, 3'b001}, waits: 1,
                prdata: 32'hBAD0_0BAD, slverr: 1'b1, hold: 5, exp: '{32'hBAD0_0BAD, 1'b1, 1'b0}};
    vecs[3] = '{cmd: '{32'h0000_1008, 1'b1, 32'hCAFE_F00D, 4'h3, 3'b101}, waits: 2,
                prdata: 32'h5555_AAAA, slverr: 1'b1, hold: 0, exp: '{32'h0, 1'b1, 1'b0}};
    vecs[4] = '{cmd: '{32'h0000_0050, 1'b0, 32'h0, 4'hF, 3'b000}, waits: 7,
                prdata: 32'hDEAD_BEEF, slverr: 1'b0, hold: 0, exp: '{32'hDEAD_BEEF, 1'b0, 1'b0}};

    cptra_rst_b = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    drive_cmd('0);
    m_apb_prdata = '0; m_apb_pready = 1'b0; m_apb_pslverr = 1'b0;
    tick(); tick();
    chk("reset_outputs", {cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, m_apb_paddr,
                          m_apb_psel, m_apb_penable, m_apb_pwrite, m_apb_pwdata, m_apb_pstrb,
                          m_apb_pprot}, 128'h0);
    cptra_rst_b = 1'b1;
    chk("release_cmd_ready_low", cmd_ready, 1'b0);
    tick();
    chk("first_cmd_ready", cmd_ready, 1'b1);

    for (int i = 0; i < 5; i++) do_xfer(vecs[i]);

    // Reset in the middle of ACCESS drops the transfer without a response.
    wait_cmd_ready();
    drive_cmd('{32'h0000_0060, 1'b0, 32'h0, 4'hF, 3'b000});
    cmd_valid = 1'b1; rsp_ready = 1'b1; m_apb_pready = 1'b0;
    tick(); cmd_valid = 1'b0;
    tick();
    chk("pre_reset_access", {m_apb_psel, m_apb_penable}, 2'b11);
    #2 cptra_rst_b = 1'b0;
    #1 chk("async_reset", {m_apb_psel, m_apb_penable, rsp_valid, cmd_ready}, 4'b0000);
    tick();
    cptra_rst_b = 1'b1; m_apb_pready = 1'b1; m_apb_prdata = 32'h0BAD_0BAD;
    tick();
    chk("post_reset_idle", {cmd_ready, m_apb_psel, m_apb_penable}, 3'b100);
    for (int k = 0; k < 4; k++) tick();
    chk("no_dropped_rsp", {rsp_valid, cmd_ready}, 2'b01);
    m_apb_pready = 1'b0;

`ifdef CALIPTRA_APB_TIMEOUT_EN
    begin
      int n;
      drive_cmd('{32'h0000_0070, 1'b0, 32'h0, 4'hF, 3'b000});
      m_apb_prdata = 32'h7777_7777;
      cmd_valid = 1'b1;
      sb_q.push_back('{32'h0, 1'b1, 1'b1});
      tick(); cmd_valid = 1'b0;
      tick();
      n = 0;
      while (m_apb_penable && n < 20) begin
        n++;
        tick();
      end
      chk("timeout_access_cycles", n, 8);
      chk("timeout_rsp", {rsp_valid, rsp_rdata, rsp_err, rsp_timeout, m_apb_psel}, {1'b1, 32'h0, 1'b1, 1'b1, 1'b0});
      tick();
      chk("timeout_idle", cmd_ready, 1'b1);
    end
`endif

    // Back-to-back commands: cmd_valid and rsp_ready held high.
    begin
      int acc = 0;
      int cyc = 0;
      m_apb_pready = 1'b1;
      rsp_ready    = 1'b1;
      while (cyc < 100 && (acc < 16 || sb_q.size() != 0)) begin
        if (m_apb_psel && !m_apb_penable) setup_cyc.push_back(cyc);
        m_apb_prdata = 32'hC0DE_0000 | m_apb_paddr;
        drive_cmd('{32'h200 + 32'(acc * 4), acc[0], 32'h9000_0000 + 32'(acc), 4'hF, 3'(acc)});
        cmd_valid = (acc < 16);
        if (cmd_ready && acc < 16) begin
          sb_q.push_back('{acc[0] ? 32'h0 : (32'hC0DE_0000 | (32'h200 + 32'(acc * 4))), 1'b0, 1'b0});
          acc++;
        end
        tick();
        cyc++;
      end
      cmd_valid = 1'b0;
      chk("b2b_setups", setup_cyc.size(), 16);
      for (int k = 1; k < setup_cyc.size(); k++)
        chk("b2b_period", setup_cyc[k] - setup_cyc[k-1], 4);
    end

    tick(); tick();
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
